// File: rtl/ro_meas_pkg.sv
// Shared types and default widths for the ring-oscillator measurement controller.
package ro_meas_pkg;

  localparam int RO_MEAS_WIN_W       = 16;
  localparam int RO_MEAS_CNT_W       = 16;
  localparam int RO_MEAS_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DRAIN,
    DONE
  } ro_meas_state_t;

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizes an asynchronous oscillator tap and emits a one-cycle pulse per rising edge.
// rst_n is active-high and synchronous, matching the controller that owns this block.
module ro_edge_sync
  import ro_meas_pkg::*;
#(
  parameter int STAGES = RO_MEAS_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop captures its predecessor's pre-edge value.
      sync_q <= {sync_q[STAGES-2:0], async_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign edge_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Sequences one ring-oscillator frequency measurement per start: settle, count edges
// over a programmable window, then report a saturating count.
module ro_meas_ctrl
  import ro_meas_pkg::*;
#(
  parameter int WIN_W      = RO_MEAS_WIN_W,
  parameter int CNT_W      = RO_MEAS_CNT_W,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ro_out,
  output logic             ro_activate,
  output logic             busy,
  output logic             count_valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);

  ro_meas_state_t   state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             act_q, busy_q, valid_q;
  logic             ro_edge;

  ro_edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (ro_out),
    .edge_o  (ro_edge)
  );

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    win_d   = win_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SETTLE;
          win_d   = win_len;
          timer_d = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = (win_q == '0) ? DRAIN : MEASURE;
        end else begin
          timer_d = timer_q + WIN_W'(1);
        end
      end
      MEASURE: begin
        // Saturation is tested before incrementing so the count never wraps.
        if (ro_edge) begin
          if (&count_q) ovf_d   = 1'b1;
          else          count_d = count_q + CNT_W'(1);
        end
        if (timer_q == win_q - WIN_W'(1)) state_d = DRAIN;
        else                              timer_d = timer_q + WIN_W'(1);
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort freezes the partial result and drops straight back to IDLE.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      win_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      win_q   <= win_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      act_q   <= (state_d == SETTLE) || (state_d == MEASURE);
      busy_q  <= (state_d == SETTLE) || (state_d == MEASURE) || (state_d == DRAIN);
      valid_q <= (state_d == DONE);
    end
  end

  assign ro_activate = act_q;
  assign busy        = busy_q;
  assign count_valid = valid_q;
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Self-checking bench for ro_meas_ctrl: a timeline-based reference model checked every
// cycle against a 16-bit and a 4-bit counter instance, plus directed literal checks.
module tb_ro_meas_ctrl;

  localparam int S    = 8;
  localparam int MAXC = 16384;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, ro_out;
  logic [15:0] win_len;
  int          ro_half;

  logic        act_b, busy_b, cv_b, ovf_b;
  logic [15:0] cnt_b;
  logic        act_s, busy_s, cv_s, ovf_s;
  logic [3:0]  cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  ro_meas_ctrl #(.WIN_W(16), .CNT_W(16), .SETTLE_CYC(S)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_len(win_len),
    .ro_out(ro_out), .ro_activate(act_b), .busy(busy_b), .count_valid(cv_b),
    .count(cnt_b), .overflow(ovf_b)
  );

  ro_meas_ctrl #(.WIN_W(16), .CNT_W(4), .SETTLE_CYC(S)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_len(win_len),
    .ro_out(ro_out), .ro_activate(act_s), .busy(busy_s), .count_valid(cv_s),
    .count(cnt_s), .overflow(ovf_s)
  );

  always #5 clk = ~clk;

  // Oscillator toggles at 3 mod 10 ns, never coincident with a rising clk edge.
  initial begin
    ro_out = 1'b0;
    #3;
    forever begin
      #(ro_half * 10);
      ro_out = ~ro_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Outputs are derived from the request timeline: with m = edges since the accepted
  // start, SETTLE is m<S, MEASURE is S<=m<S+W, DRAIN m=S+W, DONE m=S+W+1.
  bit samp [0:MAXC-1];
  int cyc = 0;
  int last_rst = -1;
  bit m_active = 1'b0;
  int m_t0, m_w, m_n = 0;
  bit e_act, e_busy, e_cv;
  bit model_ready = 1'b0;
  int mk, mp, mm;
  bit idle_prev;

  function automatic bit eff(int j);
    if (j < 0 || j <= last_rst || j >= MAXC) return 1'b0;
    return samp[j];
  endfunction

  // Synchronized rising edge seen in the cycle after edge j.
  function automatic bit edge_vis(int j);
    return eff(j - 1) & ~eff(j - 2);
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  always @(posedge clk) begin
    mk = cyc;
    cyc++;
    if (mk < MAXC) samp[mk] = ro_out;
    if (rst_n) begin
      last_rst = mk;
      m_active = 1'b0;
      m_n      = 0;
    end else begin
      idle_prev = !m_active;
      if (m_active) begin
        mp = mk - 1 - m_t0;
        if (abort) m_active = 1'b0;
        else begin
          if (mp >= S && mp < S + m_w && edge_vis(mk - 1)) m_n++;
          if (mk - m_t0 >= S + m_w + 2) m_active = 1'b0;
        end
      end
      if (idle_prev && start && !abort) begin
        m_active = 1'b1;
        m_t0     = mk;
        m_w      = int'(win_len);
        m_n      = 0;
      end
    end
    if (m_active) begin
      mm     = mk - m_t0;
      e_act  = (mm <= S + m_w - 1);
      e_busy = (mm <= S + m_w);
      e_cv   = (mm == S + m_w + 1);
    end else begin
      e_act  = 1'b0;
      e_busy = 1'b0;
      e_cv   = 1'b0;
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("big_ro_activate", act_b, e_act);
      check("big_busy", busy_b, e_busy);
      check("big_count_valid", cv_b, e_cv);
      check("big_count", cnt_b, sat(m_n, 65535));
      check("big_overflow", ovf_b, m_n > 65535);
      check("small_ro_activate", act_s, e_act);
      check("small_busy", busy_s, e_busy);
      check("small_count_valid", cv_s, e_cv);
      check("small_count", cnt_s, sat(m_n, 15));
      check("small_overflow", ovf_s, m_n > 15);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Issues one start and observes until three cycles past count_valid (or budget).
  // Cycle c is the cycle following edge E_(c-1).
  task automatic run_meas(input logic [15:0] w, input int budget,
                          output int lat, output int act, output int npulse);
    lat = -1; act = 0; npulse = 0;
    start = 1'b1; win_len = w;
    step();
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (act_b) act++;
      if (cv_b) begin
        npulse++;
        if (lat < 0) lat = c;
      end
      step();
      if (lat >= 0 && c >= lat + 3) break;
    end
  endtask

  int lat, act, np;

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; win_len = '0; ro_half = 4;
    step();
    check("reset_ro_activate", act_b, 0);
    check("reset_busy", busy_b, 0);
    check("reset_count_valid", cv_b, 0);
    check("reset_count", cnt_b, 0);
    check("reset_overflow", ovf_b, 0);
    repeat (2) step();
    rst_n = 1'b0;
    repeat (10) step();

    // Period 8, window 64.
    run_meas(16'd64, 200, lat, act, np);
    check("p8_latency", lat, 74);
    check("p8_activate_cycles", act, 72);
    check("p8_pulses", np, 1);
    check("p8_count", cnt_b, 8);
    check("p8_overflow", ovf_b, 0);

    // Period 4, window 200: 50 edges saturate the 4-bit counter.
    ro_half = 2;
    repeat (12) step();
    run_meas(16'd200, 300, lat, act, np);
    check("sat_latency", lat, 210);
    check("sat_pulses", np, 1);
    check("sat_small_count", cnt_s, 15);
    check("sat_small_overflow", ovf_s, 1);
    check("sat_big_count", cnt_b, 50);
    check("sat_big_overflow", ovf_b, 0);

    // Zero-length window with the oscillator running.
    run_meas(16'd0, 50, lat, act, np);
    check("w0_latency", lat, 10);
    check("w0_activate_cycles", act, 8);
    check("w0_count", cnt_b, 0);

    // Abort 20 cycles into MEASURE, then a normal measurement.
    ro_half = 4;
    repeat (12) step();
    start = 1'b1; win_len = 16'd64;
    step();
    start = 1'b0;
    repeat (S + 20) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_activate_low", act_b, 0);
    check("abort_busy_low", busy_b, 0);
    np = 0;
    for (int c = 0; c < 100; c++) begin
      if (cv_b) np++;
      step();
    end
    check("abort_no_pulse", np, 0);
    check("abort_partial_count", (cnt_b == 2 || cnt_b == 3), 1);
    run_meas(16'd64, 200, lat, act, np);
    check("post_abort_latency", lat, 74);
    check("post_abort_count", cnt_b, 8);

    // start during SETTLE and MEASURE is ignored (and win_len is not re-latched).
    start = 1'b1; win_len = 16'd64;
    step();
    np = 0;
    for (int c = 1; c <= 120; c++) begin
      start = (c == 4 || c == 30);
      if (c >= 4) win_len = 16'd5;
      if (cv_b) np++;
      step();
    end
    start = 1'b0;
    check("ignored_start_pulses", np, 1);
    check("ignored_start_count", cnt_b, 8);

    // start together with abort in IDLE.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy_b, 0);
    check("start_abort_activate", act_b, 0);
    step();
    check("start_abort_busy_2", busy_b, 0);

    // Reset mid-MEASURE, then a normal measurement.
    start = 1'b1; win_len = 16'd64;
    step();
    start = 1'b0;
    repeat (40) step();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    check("midrst_activate", act_b, 0);
    check("midrst_busy", busy_b, 0);
    check("midrst_count_valid", cv_b, 0);
    check("midrst_count", cnt_b, 0);
    check("midrst_overflow", ovf_b, 0);
    np = 0;
    for (int c = 0; c < 100; c++) begin
      if (cv_b) np++;
      step();
    end
    check("midrst_no_pulse", np, 0);
    run_meas(16'd64, 200, lat, act, np);
    check("post_rst_count", cnt_b, 8);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) ro_half = $urandom_range(2, 7);
      start   = ($urandom_range(0, 7) == 0);
      abort   = ($urandom_range(0, 199) == 0);
      rst_n   = ($urandom_range(0, 999) == 0);
      win_len = 16'($urandom_range(0, 80));
      step();
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b0;
    repeat (120) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ro_meas_ctrl.md
# ro_meas_ctrl

Measurement controller for the ring-oscillator block. It sequences one frequency measurement per request: enable the oscillator, wait a fixed settle time, count oscillator rising edges over a programmable window of `clk` cycles, then disable the oscillator and report the count. It sits between the host/register interface and the `ro` instance, and is the only driver of `ro_activate`.

## Interface
Parameters:
- `WIN_W`, 16: width of the window-length input.
- `CNT_W`, 16: width of the edge counter and result.
- `SETTLE_CYC`, 8: `clk` cycles between enabling the oscillator and opening the window. Must be ≥ 3, to cover the enable register and synchronizer latency.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-high reset. The name follows the design; a value of 1 resets the block.
- `start`  in  1  single-cycle request. Honoured only in IDLE.
- `abort`  in  1  cancels any measurement in progress.
- `win_len`  in  WIN_W  window length in `clk` cycles. Latched on an accepted `start`.
- `ro_out`  in  1  oscillator output. Asynchronous to `clk`.
- `ro_activate`  out  1  oscillator enable, driven from a register.
- `busy`  out  1  high from the cycle after `start` is accepted through DRAIN.
- `count_valid`  out  1  single-cycle pulse when a result is ready.
- `count`  out  CNT_W  last result. Held until the next accepted `start`.
- `overflow`  out  1  the result saturated. Held with `count`.

## Operation
- States: IDLE, SETTLE, MEASURE, DRAIN, DONE.
- Edge detection: `ro_out` passes through a 2-flop synchronizer, then a third flop; edge = `s2 & ~s3`. Valid only for oscillator frequencies below `clk`/2, which is the intended use.
- Transitions and per-state behaviour:
  - IDLE → SETTLE on `start`:
    - latch `win_len`;
    - clear `count`, `overflow` and the timer;
    - set `ro_activate` = 1 and `busy` = 1.
  - SETTLE: the timer counts `SETTLE_CYC` cycles, then the FSM enters MEASURE. If the latched `win_len` is 0, it goes to DRAIN instead and the result is count = 0.
  - MEASURE: lasts exactly `win_len` cycles. Each detected edge increments `count`. At all-ones, `count` saturates and `overflow` = 1, sticky. On exit, `ro_activate` = 0.
  - DRAIN: one cycle, with edges ignored. Then the FSM enters DONE.
  - DONE: one cycle with `count_valid` = 1 and `busy` = 0, then IDLE.
- `start` outside IDLE is ignored. It is not queued.
- `abort` in any non-IDLE state:
  - next state is IDLE;
  - `ro_activate` = 0 and `busy` = 0;
  - no `count_valid` pulse;
  - `count` and `overflow` keep their partial values.
- `abort` and `start` together in IDLE: `abort` wins and `start` is dropped.
- Edges outside MEASURE are never counted. This includes edges from the synchronizer pipeline after the window closes.

## Timing
- Reset values, applied on the edge where `rst_n` = 1: state IDLE; `ro_activate`, `busy`, `count_valid`, `overflow` = 0; `count` = 0; synchronizer flops = 0.
- Reset mid-operation behaves identically to power-on reset. It returns to IDLE with no `count_valid` pulse.
- Let the edge that samples `start` = E0, with S = `SETTLE_CYC` and W = latched `win_len`:
  - `ro_activate` and `busy` are high after E0;
  - MEASURE covers the cycles after edges E_S … E_(S+W−1);
  - `ro_activate` is low after E_(S+W);
  - `count_valid` is high for the single cycle after E_(S+W+1).
- Total request-to-result latency: S+W+2 cycles. A new `start` is accepted in the cycle after DONE at the earliest.
- Arithmetic:
  - `count` increments by at most 1 per cycle;
  - saturation is checked before the increment (no wrap);
  - the window timer is WIN_W bits wide and compares against the latched `win_len`.

## Structure
- Package `ro_meas_pkg`:
  - state enum `ro_meas_state_t` (IDLE, SETTLE, MEASURE, DRAIN, DONE);
  - default width constants `RO_MEAS_WIN_W` and `RO_MEAS_CNT_W`;
  - `RO_MEAS_SYNC_STAGES` = 2.
- Sub-module `ro_edge_sync`: synchronizer plus rising-edge pulse generator. It has its own reset and a one-bit `edge` output, and is reusable for other asynchronous ring-oscillator taps.
- Top level: FSM, settle/window timer, saturating counter and output registers.

## Test plan
- Oscillator modelled as a square wave of period 8 `clk`, with S = 8 and `win_len` = 64 → `count_valid` 74 cycles after `start`, `count` = 8, `overflow` = 0, `ro_activate` high for exactly 72 cycles.
- CNT_W = 4, oscillator period 4 `clk`, `win_len` = 200 → `count` = 15, `overflow` = 1, single `count_valid` pulse.
- `win_len` = 0 → `count_valid` at S+2 = 10 cycles, `count` = 0, no edges counted even with the oscillator running.
- `abort` 20 cycles into MEASURE → `ro_activate` and `busy` low the next cycle, no `count_valid`, `count` holds its partial value; a following `start` works normally.
- `start` pulsed during SETTLE and MEASURE → ignored, only one result produced; `start` together with `abort` in IDLE → stays IDLE.
- `rst_n` = 1 mid-MEASURE → all outputs 0 the next cycle, no `count_valid`; a subsequent measurement with period 8 and `win_len` = 64 returns `count` = 8.
